// File: rtl/m_div_pkg.sv
// Shared types and constants for the iterative M-unit divider.
// Op encoding follows RISC-V funct3[1:0] for DIV/DIVU/REM/REMU.
package m_div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    // op[OP_SIGNED_BIT] == 0 selects a signed op; op[OP_REM_BIT] selects the remainder.
    localparam int OP_SIGNED_BIT = 0;
    localparam int OP_REM_BIT    = 1;

endpackage : m_div_pkg

// File: rtl/m_div_regs.sv
// Remainder (R), shifted divisor (D) and quotient (Z) registers of the
// restoring divider, with their load / shift-subtract / hold muxes.
module m_div_regs #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] r_init,
    input  logic [WIDTH-1:0] d_init,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] z
);

    logic [2*WIDTH-2:0] d;
    logic [2*WIDTH-2:0] d_nxt;
    logic [WIDTH-1:0]   r_nxt;
    logic [WIDTH-1:0]   z_nxt;

    logic               borrow;
    logic [WIDTH-2:0]   diff_hi_unused;
    logic [WIDTH-1:0]   diff_lo;

    // A non-negative difference always fits in WIDTH bits, so only the
    // borrow and the low half are ever consumed.
    assign {borrow, diff_hi_unused, diff_lo} = {{WIDTH{1'b0}}, r} - {1'b0, d};

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        r_nxt = r;
        d_nxt = d;
        z_nxt = z;
        if (load) begin
            r_nxt = r_init;
            d_nxt = {d_init, {(WIDTH-1){1'b0}}};
            z_nxt = '0;
        end else if (step) begin
            if (!borrow) begin
                r_nxt = diff_lo;
            end
            z_nxt = {z[WIDTH-2:0], ~borrow};
            d_nxt = d >> 1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (!resetn) begin
            r <= '0;
            d <= '0;
            z <= '0;
        end else begin
            r <= r_nxt;
            d <= d_nxt;
            z <= z_nxt;
        end
    end

endmodule : m_div_regs

// File: rtl/m_div_iter.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU) with start/done handshake.
// Optional M_DIV_FASTPATH_EN: divide-by-zero and MIN/-1 complete in one cycle.
module m_div_iter
    import m_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state;
    div_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             rem_q;
    logic             neg_q;
    logic             neg_r;

    logic             req_signed;
    logic             req_rem;
    logic             rs1_neg;
    logic             rs2_neg;
    logic             rs2_zero;
    logic [WIDTH-1:0] rs1_mag;
    logic [WIDTH-1:0] rs2_mag;

    logic             load;
    logic             step;
    logic             fix;
    logic             fast_hit;
    logic [WIDTH-1:0] r_val;
    logic [WIDTH-1:0] z_val;
    logic [WIDTH-1:0] fix_val;

    assign req_signed = ~op[OP_SIGNED_BIT];
    assign req_rem    = op[OP_REM_BIT];
    assign rs1_neg    = req_signed & rs1[WIDTH-1];
    assign rs2_neg    = req_signed & rs2[WIDTH-1];
    assign rs2_zero   = (rs2 == '0);
    assign rs1_mag    = rs1_neg ? -rs1 : rs1;
    assign rs2_mag    = rs2_neg ? -rs2 : rs2;

`ifdef M_DIV_FASTPATH_EN
    logic [WIDTH-1:0] fast_val;

    assign fast_hit = rs2_zero | (req_signed & (rs1 == MIN_VAL) & (rs2 == '1));
    assign fast_val = req_rem ? (rs2_zero ? rs1 : '0)
                              : (rs2_zero ? '1  : MIN_VAL);
`else
    assign fast_hit = 1'b0;
`endif

    m_div_regs #(
        .WIDTH (WIDTH)
    ) u_regs (
        .clk    (clk),
        .resetn (resetn),
        .load   (load),
        .step   (step),
        .r_init (rs1_mag),
        .d_init (rs2_mag),
        .r      (r_val),
        .z      (z_val)
    );

    // Divide-by-zero and MIN/-1 need no special case: neg_q is suppressed
    // for a zero divisor and |MIN| is representable unsigned.
    assign fix_val = rem_q ? (neg_r ? -r_val : r_val)
                           : (neg_q ? -z_val : z_val);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        fix       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = fast_hit ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (kill) begin
                    state_nxt = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_nxt = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                if (kill) begin
                    state_nxt = ST_IDLE;
                end else begin
                    fix       = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            cnt   <= '0;
            rem_q <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                cnt   <= CNT_INIT;
                rem_q <= req_rem;
                neg_q <= req_signed & (rs1[WIDTH-1] ^ rs2[WIDTH-1]) & ~rs2_zero;
                neg_r <= rs1_neg;
            end else if (step) begin
                cnt <= cnt - CNT_LAST;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result <= '0;
        end else if (fix) begin
            result <= fix_val;
`ifdef M_DIV_FASTPATH_EN
        end else if (load && fast_hit) begin
            result <= fast_val;
`endif
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule : m_div_iter
